// File: rtl/mem_requester.sv
// Bus initiator that turns single CPU-side requests into BRAM strobe/addr/data sequences,
// hiding read latency and fetching 16-bit little-endian operands as two byte reads.
module mem_requester #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_word,
  input  logic                    req_zp_wrap,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    busy,
  output logic                    mem_rd_enable,
  output logic                    mem_wr_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("mem_requester: READ_LATENCY must be 1 or 2");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  localparam logic [1:0] LO_CNT = 2'(READ_LATENCY);
  localparam logic [1:0] HI_CNT = 2'(READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(8'hFF);

  logic [1:0]            state;
  logic [1:0]            lat_cnt;
  logic                  word_q;
  logic [ADDR_WIDTH-1:0] hi_addr_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] hi_addr;

  // Zero-page style wrap keeps the high-byte fetch inside the 256-byte page of A.
  always_comb begin
    addr_inc = req_addr + ADDR_WIDTH'(1);
    hi_addr  = addr_inc;
    if (req_zp_wrap)
      hi_addr = (req_addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
  end

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      word_q        <= 1'b0;
      hi_addr_q     <= '0;
      lo_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            word_q    <= req_word & ~req_write;
            hi_addr_q <= hi_addr;
            mem_addr  <= req_addr;
            lat_cnt   <= 2'd0;
            if (req_write) begin
              mem_wr_enable <= 1'b1;
              mem_wr_data   <= req_wdata;
              state         <= WR;
            end else begin
              mem_rd_enable <= 1'b1;
              state         <= RD;
            end
          end
        end
        WR: begin
          mem_wr_enable <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= IDLE;
        end
        RD: begin
          lat_cnt <= lat_cnt + 2'd1;
          // A word read keeps the strobe up one more cycle for the high byte.
          if (lat_cnt == 2'd0 && word_q)
            mem_addr <= hi_addr_q;
          else
            mem_rd_enable <= 1'b0;
          if (lat_cnt == LO_CNT) begin
            if (word_q) begin
              lo_q <= mem_rd_data;
            end else begin
              rsp_data  <= {{DATA_WIDTH{1'b0}}, mem_rd_data};
              rsp_valid <= 1'b1;
              state     <= IDLE;
            end
          end
          if (lat_cnt == HI_CNT) begin
            rsp_data  <= {mem_rd_data, lo_q};
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
